// File: rtl/board_tx.sv
// board_tx -- serialises a 9x9 board snapshot onto a byte-wide valid/ready link.
//
// Packet: HEADER, 21 payload bytes (four 2-bit cells per byte, cell k =
// row*9+col, cell 4j in bits [1:0] of byte j, cells 81..83 padded with
// CELL_E), then optionally an XOR checksum of the payload bytes.
//
// Build option: define BOARD_TX_CHECKSUM_EN to append the checksum byte
// (23-byte packet); leave it undefined for a 22-byte packet with no CSUM
// state and no checksum register.
//
// Ports:
//   clk_in    system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     send request, sampled in IDLE only
//   board     9x9 board, board[row][col] = 2-bit cell code
//   tx_ready  link accepts a byte this cycle
//   tx_data   byte offered to the link
//   tx_valid  tx_data is valid
//   busy      high from start acceptance until the end of FIN
//   done      one-cycle pulse after the final byte transfers

module board_tx #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter logic [1:0] CELL_E = 2'b00
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8:0][8:0][1:0]   board,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    output logic                   busy,
    output logic                   done
);

`ifdef BOARD_TX_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, FIN} state_t;
`endif

    state_t       state;
    logic [161:0] snap;     // flattened board: cell k lives at bits [2k+1:2k]
    logic [4:0]   cnt;      // index of the payload byte currently offered
`ifdef BOARD_TX_CHECKSUM_EN
    logic [7:0]   csum;     // XOR of payload bytes already transferred
`endif

    logic xfer;
    assign xfer = tx_valid & tx_ready;

    // Payload byte j: cells 4j..4j+3, padding past the last real cell.
    function automatic logic [7:0] pay_byte(input logic [161:0] s, input logic [4:0] j);
        logic [7:0] b;
        b = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            int unsigned k;
            k = 4 * j + i;
            if (k < 81)
                b[2*i +: 2] = s[2*k +: 2];
            else
                b[2*i +: 2] = CELL_E;
        end
        return b;
    endfunction

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            snap     <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef BOARD_TX_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap     <= board;
                        state    <= HDR;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_data  <= HEADER;
                        cnt      <= '0;
`ifdef BOARD_TX_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        state   <= PAYLOAD;
                        cnt     <= '0;
                        tx_data <= pay_byte(snap, 5'd0);
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
`ifdef BOARD_TX_CHECKSUM_EN
                        csum <= csum ^ tx_data;
`endif
                        if (cnt == 5'd20) begin
`ifdef BOARD_TX_CHECKSUM_EN
                            // Checksum byte includes the byte transferring now.
                            state   <= CSUM;
                            tx_data <= csum ^ tx_data;
`else
                            state    <= FIN;
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            done     <= 1'b1;
`endif
                        end else begin
                            cnt     <= cnt + 5'd1;
                            tx_data <= pay_byte(snap, cnt + 5'd1);
                        end
                    end
                end
`ifdef BOARD_TX_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        state    <= FIN;
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        done     <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt   <= '0;
`ifdef BOARD_TX_CHECKSUM_EN
                    csum  <= '0;
`endif
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_tx.sv
// tb_board_tx -- self-checking bench for board_tx.
// A behavioural model pushes every expected packet byte into a queue when a
// packet is started; a negedge monitor pops and compares each transferred
// byte, checks stall stability and counts done pulses. A vector table adds
// hand-derived header/payload/checksum constants; directed sequences cover
// stalls, mid-packet start/board changes and mid-packet reset.
// Follows BOARD_TX_CHECKSUM_EN the same way as the design.

module tb_board_tx;

    logic                 clk_in;
    logic                 reset;
    logic                 start;
    logic [8:0][8:0][1:0] board;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 busy;
    logic                 done;

`ifdef BOARD_TX_CHECKSUM_EN
    localparam int PKT_LEN = 23;
`else
    localparam int PKT_LEN = 22;
`endif

    board_tx #(.HEADER(8'hA5), .CELL_E(2'b00)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .start    (start),
        .board    (board),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc++;

    typedef struct {
        logic [8:0][8:0][1:0] brd;
        logic [7:0]           b0;
        logic [7:0]           b20;
        logic [7:0]           cs;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] exp_q[$];
    logic [7:0] rx[32];
    int         rx_cnt = 0;
    int         done_cnt = 0;
    int         last_xfer_cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    int         rdy_mode = 0;
    int         phase = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [8:0][8:0][1:0] b, input int j);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = 4 * j + i;
            if (k < 81) r[2*i +: 2] = b[k / 9][k % 9];
        end
        return r;
    endfunction

    task automatic push_expected(input logic [8:0][8:0][1:0] b);
        logic [7:0] cs;
        logic [7:0] m;
        cs = '0;
        exp_q.push_back(8'hA5);
        for (int j = 0; j < 21; j++) begin
            m = model_byte(b, j);
            cs ^= m;
            exp_q.push_back(m);
        end
`ifdef BOARD_TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    // Link-side ready driver: always ready, or the repeating 1,0,0 pattern.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (rdy_mode == 0) begin
                tx_ready = 1'b1;
            end else begin
                tx_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end
        end
    end

    // Monitor: a transfer happens at the next rising edge when valid&ready here.
    always @(negedge clk_in) begin
        if (!reset) begin
            if (stall_prev) begin
                checks++;
                if (!(tx_valid && tx_data == stall_data)) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%0h expected valid=1 data=%0h", tx_valid, tx_data, stall_data);
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        errors++;
                        $display("FAIL byte%0d: got %0h expected %0h", rx_cnt, tx_data, e);
                    end
                end
                if (rx_cnt < 32) rx[rx_cnt] = tx_data;
                rx_cnt++;
                last_xfer_cyc = cyc;
            end
            if (done) done_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called just after a rising edge; start is accepted at the next edge.
    task automatic begin_packet(input logic [8:0][8:0][1:0] b);
        rx_cnt = 0;
        done_cnt = 0;
        exp_q.delete();
        push_expected(b);
        board = b;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        chk("first_valid", {31'd0, tx_valid}, 32'd1);
        chk("busy_at_start", {31'd0, busy}, 32'd1);
        chk("header", {24'd0, tx_data}, 32'h0000_00A5);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
        end else begin
            chk("done_after_last_byte", cyc, last_xfer_cyc + 1);
            chk("busy_in_fin", {31'd0, busy}, 32'd1);
            chk("pkt_len", rx_cnt, PKT_LEN);
            chk("queue_empty", exp_q.size(), 0);
            @(negedge clk_in);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("busy_cleared", {31'd0, busy}, 32'd0);
        end
        repeat (30) @(negedge clk_in);
        chk("done_count", done_cnt, 1);
        chk("idle_no_valid", {31'd0, tx_valid}, 32'd0);
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        logic [8:0][8:0][1:0] b11;
        int n;

        vecs[0].brd = '0;
        vecs[0].b0 = 8'h00; vecs[0].b20 = 8'h00; vecs[0].cs = 8'h00;
        vecs[1].brd = '0;
        vecs[1].brd[0][0] = 2'b10;
        vecs[1].brd[0][1] = 2'b01;
        vecs[1].brd[8][8] = 2'b01;
        vecs[1].b0 = 8'h06; vecs[1].b20 = 8'h01; vecs[1].cs = 8'h07;
        vecs[2].brd = '1;
        vecs[2].b0 = 8'hFF; vecs[2].b20 = 8'h03; vecs[2].cs = 8'h03;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                vecs[3].brd[r][c] = 2'b01;
        vecs[3].b0 = 8'h55; vecs[3].b20 = 8'h01; vecs[3].cs = 8'h01;

        reset = 1'b1;
        start = 1'b0;
        board = '0;
        #3;
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        @(posedge clk_in);
        #2;
        reset = 1'b0;
        @(posedge clk_in);
        #2;

        // Table: full packets with ready held high.
        for (int v = 0; v < 4; v++) begin
            begin_packet(vecs[v].brd);
            wait_done("table");
            chk("tbl_hdr", {24'd0, rx[0]}, 32'h0000_00A5);
            chk("tbl_b0", {24'd0, rx[1]}, {24'd0, vecs[v].b0});
            chk("tbl_b20", {24'd0, rx[21]}, {24'd0, vecs[v].b20});
`ifdef BOARD_TX_CHECKSUM_EN
            chk("tbl_csum", {24'd0, rx[22]}, {24'd0, vecs[v].cs});
`endif
        end

        // Ready stalls 1,0,0 repeating.
        rdy_mode = 1;
        phase = 0;
        begin_packet(vecs[1].brd);
        wait_done("stall");
        chk("stall_b0", {24'd0, rx[1]}, 32'h06);
        rdy_mode = 0;
        @(posedge clk_in);
        #2;

        // Board changed and start re-pulsed mid-packet.
        b11 = '1;
        begin_packet(vecs[1].brd);
        n = 0;
        while (rx_cnt < 5 && n < 100) begin
            @(posedge clk_in);
            n++;
        end
        #2;
        board = b11;
        start = 1'b1;
        @(posedge clk_in);
        #2;
        start = 1'b0;
        wait_done("restart");
        chk("restart_b0", {24'd0, rx[1]}, 32'h06);

        // Reset after payload byte 5 transfers.
        begin_packet(vecs[1].brd);
        n = 0;
        while (rx_cnt < 7 && n < 100) begin
            @(posedge clk_in);
            n++;
        end
        chk("reached_byte5", {31'd0, rx_cnt >= 7}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_data", {24'd0, tx_data}, 32'd0);
        exp_q.delete();
        @(posedge clk_in);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            chk("post_rst_idle", {31'd0, tx_valid | busy}, 32'd0);
        end
        @(posedge clk_in);
        #2;
        begin_packet(vecs[3].brd);
        wait_done("after_reset");
        chk("after_rst_b20", {24'd0, rx[21]}, 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
